// File: rtl/fifo_ctrl_4x16.sv
// rtl/fifo_ctrl_4x16.sv - pointer/flag controller for a 4-entry 1r1w FIFO RAM with registered read address
module fifo_ctrl_4x16 #(
    parameter int DW       = 16,
    parameter int AW       = 2,
    parameter int AFULL_TH = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          full,
    output logic          empty,
    output logic          afull,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic          udf,
    output logic [AW-1:0] ram_wadr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_wen,
    output logic [AW-1:0] ram_radr,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [AW:0] DEPTH     = (AW+1)'(1 << AW);
    localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_TH);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count_q;
    logic          dout_valid_q;
    logic          ovf_q;
    logic          udf_q;
    logic          flush;
    logic          push_ok;
    logic          pop_ok;

    assign flush   = rst | clr;
    assign full    = (count_q == DEPTH);
    assign empty   = (count_q == '0);
    assign afull   = (count_q >= AFULL_LVL);
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    assign count      = count_q;
    assign dout_valid = dout_valid_q;
    assign ovf        = ovf_q;
    assign udf        = udf_q;

    assign ram_wadr  = wptr;
    assign ram_wdata = din;
    assign ram_wen   = push_ok;
    assign ram_radr  = rptr;

    // The RAM latches ram_radr at the accepting edge, so its output is already the popped word.
    assign dout = ram_rdata;

    always_ff @(posedge clk) begin
        if (flush) begin
            wptr         <= '0;
            rptr         <= '0;
            count_q      <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
            end
            count_q      <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
            dout_valid_q <= pop_ok;
            if (push && full) begin
                ovf_q <= 1'b1;
            end
            if (pop && empty) begin
                udf_q <= 1'b1;
            end
        end
    end

endmodule
